latch_bank_arbiter: RTL and testbench
=====================================

// Module: latch_bank_arbiter
// PURPOSE
//  Shares one bank of NREG octal data latches (74273-style, clear-to-zero) between
//  two CPU write ports: A = main CPU, B = sub CPU. Typical users: sound latches and
//  scroll latches. Each port runs a 4-phase req/ack handshake; conflicts resolve round-robin.
//  A per-latch FULL flag is set on write and cleared by the consumer. In STRICT mode a
//  write to a FULL latch stalls until it is cleared.
// PARAMETERS
//  NREG    4   number of 8-bit latches (1..16)
//  AW      2   address width; must satisfy 2**AW >= NREG
//  STRICT  0   1 = stall writes to a FULL latch; 0 = overwrite
// PORTS
//  Clk     in   1        sole clock; everything updates on posedge
//  RESET   in   1        synchronous, active-high reset
//  a_req   in   1        port A write request (4-phase)
//  a_addr  in   AW       port A latch index
//  a_data  in   8        port A write data
//  a_ack   out  1        port A acknowledge
//  b_req   in   1        port B write request
//  b_addr  in   AW       port B latch index
//  b_data  in   8        port B write data
//  b_ack   out  1        port B acknowledge
//  clr     in   NREG     per-latch FULL clear strobe (consumer read)
//  Q       out  NREG*8   latch contents; latch i = Q[8i+7:8i]
//  full    out  NREG     per-latch FULL flags
//  busy    out  1        high whenever state != IDLE
// BEHAVIOUR
//  Reset (RESET high at an edge): Q=0, full=0, a_ack=b_ack=0, busy=0, state=IDLE, last=B.
//   Reset overrides everything else in that cycle.
//  Eligibility: a port is eligible when req=1 AND (STRICT==0 OR addr>=NREG OR !full[addr]).
//  FSM states: IDLE, WR, ACK.
//   IDLE: no port eligible -> stay in IDLE.
//   IDLE, one port eligible -> grant it. Both eligible -> grant the port != last (A wins first).
//    On grant: capture addr/data into holding registers; next state WR.
//   WR: if addr<NREG then Q[addr]<=data and full[addr]<=1; last<=grantee; next state ACK.
//   ACK: grantee ack=1. When grantee req is sampled 0, go to IDLE; ack is 0 from that edge.
//  Latency: req sampled at edge E0 -> Q, full and ack update at E0+1. Back-to-back grants
//   are >= 3 cycles apart.
//  Out-of-range address (addr>=NREG): full handshake runs, no latch or flag changes.
//  Clear vs write on the same latch in the same cycle: the write wins, full=1.
//   Clear on other latches is applied in parallel.
//  STRICT stall: a request that is not eligible stays pending with ack=0. The other port may
//   be granted meanwhile. The stalled port is re-evaluated every IDLE cycle.
//  Requester drops req during WR (protocol violation): the write completes, and ack is a
//   1-cycle pulse in ACK.
//  Data and addr are sampled only at grant. Changes after grant have no effect.
//  Reset during WR or ACK aborts the operation: no ack is issued and a write not yet
//   committed is lost. The requester must re-issue.
//  Only one write per cycle ever reaches the bank.
// STRUCTURE
//  Shared package latch_bank_pkg holds:
//   - enum lb_state_t {IDLE, WR, ACK}
//   - localparam LB_DW = 8
//   - port-id constants PORT_A = 0, PORT_B = 1
//  Sub-module rr_arb2: 2-way round-robin arbiter (inputs elig[1:0] and last; outputs a
//   one-hot grant), combinational.
//  Latch bank, flags and FSM live in this module.
// TESTING
//  1. Reset, then A writes addr1=0x5A
//     -> Q[15:8]=0x5A and full=4'b0010 one edge after grant.
//     -> a_ack stays high until a_req drops, then low the next edge.
//  2. A and B request in the same cycle (A:0=0x11, B:2=0x22)
//     -> A is served first, then B.
//     -> Q[7:0]=0x11, Q[23:16]=0x22, full=4'b0101, acks never both high.
//  3. Repeat scenario 2 with last=A -> B is granted first.
//  4. STRICT=1, full[3]=1, A writes addr3
//     -> a_ack stays low, B's write to addr0 completes meanwhile.
//     -> Pulse clr[3]; A then completes and Q[31:24] holds A's data.
//  5. clr[2] pulses in the same cycle as WR to addr2 -> full[2]=1 afterwards.
//  6. Assert RESET during ACK of a B write -> b_ack=0 next edge, Q=0, full=0, busy=0.
//     An out-of-range write (NREG=3, addr=3) acks and leaves Q unchanged.

Source files
------------

// File: rtl/latch_bank_pkg.sv
// Shared types and constants for the two-port latch bank arbiter.
// No logic here: FSM state encoding, data width and port identifiers.
package latch_bank_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WR   = 2'd1,
    ACK  = 2'd2
  } lb_state_t;

  localparam int LB_DW = 8;

  localparam logic PORT_A = 1'b0;
  localparam logic PORT_B = 1'b1;

endpackage

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; bit 0 = port A, bit 1 = port B, one-hot grant.
// Latency: combinational; backpressure: none, an ineligible port is simply not granted.
module rr_arb2
  import latch_bank_pkg::*;
(
  input  logic [1:0] elig,
  input  logic       last,
  output logic [1:0] gnt
);

  always_comb begin
    gnt = elig;
    // Contention: favour whichever port was not served most recently.
    if (&elig) begin
      gnt = (last == PORT_B) ? 2'b01 : 2'b10;
    end
  end

endmodule

// File: rtl/latch_bank_arbiter.sv
// Bank of NREG 8-bit clear-to-zero latches shared by two 4-phase req/ack write ports.
// Latency: grant edge + 1 for Q/full/ack; backpressure: ack withheld, STRICT stalls writes to FULL latches.
module latch_bank_arbiter
  import latch_bank_pkg::*;
#(
  parameter int NREG   = 4,
  parameter int AW     = 2,
  parameter int STRICT = 0
) (
  input  logic                  Clk,
  input  logic                  RESET,
  input  logic                  a_req,
  input  logic [AW-1:0]         a_addr,
  input  logic [LB_DW-1:0]      a_data,
  output logic                  a_ack,
  input  logic                  b_req,
  input  logic [AW-1:0]         b_addr,
  input  logic [LB_DW-1:0]      b_data,
  output logic                  b_ack,
  input  logic [NREG-1:0]       clr,
  output logic [NREG*LB_DW-1:0] Q,
  output logic [NREG-1:0]       full,
  output logic                  busy
);

  localparam logic [AW:0] NREG_W = (AW+1)'(NREG);

  lb_state_t                   state, state_nxt;
  logic                        gnt_port;
  logic                        last;
  logic [AW-1:0]               h_addr;
  logic [LB_DW-1:0]            h_data;
  logic [NREG-1:0][LB_DW-1:0]  bank;
  logic [2**AW-1:0]            full_pad;
  logic [NREG-1:0]             wr_hit;
  logic                        a_elig, b_elig;
  logic [1:0]                  gnt;
  logic                        load, commit;

  // Zero-padded so any address can index it; out-of-range slots read as not full.
  always_comb begin
    full_pad = '0;
    for (int i = 0; i < NREG; i++) begin
      full_pad[i] = full[i];
    end
  end

  assign a_elig = a_req && ((STRICT == 0) || ({1'b0, a_addr} >= NREG_W) || !full_pad[a_addr]);
  assign b_elig = b_req && ((STRICT == 0) || ({1'b0, b_addr} >= NREG_W) || !full_pad[b_addr]);

  rr_arb2 u_arb (
    .elig ({b_elig, a_elig}),
    .last (last),
    .gnt  (gnt)
  );

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    commit    = 1'b0;
    a_ack     = 1'b0;
    b_ack     = 1'b0;
    case (state)
      IDLE: begin
        if (|gnt) begin
          load      = 1'b1;
          state_nxt = WR;
        end
      end
      WR: begin
        commit    = 1'b1;
        state_nxt = ACK;
      end
      ACK: begin
        a_ack = (gnt_port == PORT_A);
        b_ack = (gnt_port == PORT_B);
        if (!((gnt_port == PORT_A) ? a_req : b_req)) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Out-of-range holding addresses match no latch, so the handshake runs with no bank effect.
  always_comb begin
    wr_hit = '0;
    for (int i = 0; i < NREG; i++) begin
      wr_hit[i] = commit && (h_addr == AW'(i));
    end
  end

  always_ff @(posedge Clk) begin
    if (RESET) begin
      state    <= IDLE;
      last     <= PORT_B;
      gnt_port <= PORT_A;
      h_addr   <= '0;
      h_data   <= '0;
      bank     <= '0;
      full     <= '0;
    end else begin
      state <= state_nxt;
      if (load) begin
        gnt_port <= gnt[1];
        h_addr   <= gnt[1] ? b_addr : a_addr;
        h_data   <= gnt[1] ? b_data : a_data;
      end
      if (commit) begin
        last <= gnt_port;
      end
      // Set beats clear on the written latch; clears elsewhere apply in parallel.
      for (int i = 0; i < NREG; i++) begin
        full[i] <= wr_hit[i] | (full[i] & ~clr[i]);
        if (wr_hit[i]) begin
          bank[i] <= h_data;
        end
      end
    end
  end

  assign Q    = bank;
  assign busy = (state != IDLE);

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Directed bench for latch_bank_arbiter: three instances (default, STRICT, NREG=3).
module tb_latch_bank_arbiter;

  logic Clk;
  logic [2:0]      rst;
  logic [2:0]      a_req, b_req;
  logic [2:0][1:0] a_addr, b_addr;
  logic [2:0][7:0] a_data, b_data;
  logic [2:0][3:0] clr;

  wire  [2:0]       a_ack, b_ack, busy;
  wire  [2:0][31:0] q;
  wire  [2:0][3:0]  full;
  wire  [23:0]      q2_w;
  wire  [2:0]       full2_w;

  int n_cmp = 0;
  int n_err = 0;
  int both_hi = 0;

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  latch_bank_arbiter #(.NREG(4), .AW(2), .STRICT(0)) u_d0 (
    .Clk(Clk), .RESET(rst[0]),
    .a_req(a_req[0]), .a_addr(a_addr[0]), .a_data(a_data[0]), .a_ack(a_ack[0]),
    .b_req(b_req[0]), .b_addr(b_addr[0]), .b_data(b_data[0]), .b_ack(b_ack[0]),
    .clr(clr[0]), .Q(q[0]), .full(full[0]), .busy(busy[0])
  );

  latch_bank_arbiter #(.NREG(4), .AW(2), .STRICT(1)) u_d1 (
    .Clk(Clk), .RESET(rst[1]),
    .a_req(a_req[1]), .a_addr(a_addr[1]), .a_data(a_data[1]), .a_ack(a_ack[1]),
    .b_req(b_req[1]), .b_addr(b_addr[1]), .b_data(b_data[1]), .b_ack(b_ack[1]),
    .clr(clr[1]), .Q(q[1]), .full(full[1]), .busy(busy[1])
  );

  latch_bank_arbiter #(.NREG(3), .AW(2), .STRICT(0)) u_d2 (
    .Clk(Clk), .RESET(rst[2]),
    .a_req(a_req[2]), .a_addr(a_addr[2]), .a_data(a_data[2]), .a_ack(a_ack[2]),
    .b_req(b_req[2]), .b_addr(b_addr[2]), .b_data(b_data[2]), .b_ack(b_ack[2]),
    .clr(clr[2][2:0]), .Q(q2_w), .full(full2_w), .busy(busy[2])
  );

  assign q[2]    = {8'h00, q2_w};
  assign full[2] = {1'b0, full2_w};

  always @(negedge Clk) begin
    for (int d = 0; d < 3; d++) begin
      if (a_ack[d] && b_ack[d]) both_hi++;
    end
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic rqst(input int d, input bit p, input logic [1:0] ad, input logic [7:0] dt);
    if (p) begin
      b_req[d] = 1'b1; b_addr[d] = ad; b_data[d] = dt;
    end else begin
      a_req[d] = 1'b1; a_addr[d] = ad; a_data[d] = dt;
    end
  endtask

  // Called at a negedge; counts negedges until the port's ack is seen.
  task automatic wait_ack(input int d, input bit p, input int exp_lat, input string tag);
    int n = 0;
    while (!(p ? b_ack[d] : a_ack[d]) && n < 12) begin
      @(negedge Clk);
      n++;
    end
    chk({tag, "_lat"}, n, exp_lat);
    chk({tag, "_other_ack"}, p ? a_ack[d] : b_ack[d], 0);
  endtask

  task automatic drop(input int d, input bit p, input string tag);
    if (p) b_req[d] = 1'b0; else a_req[d] = 1'b0;
    @(negedge Clk);
    chk({tag, "_ack_lo"}, p ? b_ack[d] : a_ack[d], 0);
  endtask

  initial begin
    rst = 3'b111;
    a_req = '0; b_req = '0; a_addr = '0; b_addr = '0;
    a_data = '0; b_data = '0; clr = '0;
    repeat (2) @(negedge Clk);
    rst = 3'b000;

    chk("rst_q",    q[0], 32'h0);
    chk("rst_full", full[0], 4'b0000);
    chk("rst_busy", busy[0], 0);
    chk("rst_acks", {a_ack[0], b_ack[0]}, 2'b00);

    // Single write from A; ack holds until req drops
    rqst(0, 0, 2'd1, 8'h5A);
    wait_ack(0, 0, 2, "s1");
    chk("s1_q1",   q[0][15:8], 8'h5A);
    chk("s1_full", full[0], 4'b0010);
    @(negedge Clk);
    chk("s1_hold", a_ack[0], 1);
    drop(0, 0, "s1");
    chk("s1_idle", busy[0], 0);

    // last = A now: simultaneous requests serve B first
    rqst(0, 0, 2'd0, 8'h33);
    rqst(0, 1, 2'd2, 8'h44);
    wait_ack(0, 1, 2, "s3_b");
    chk("s3_q2",   q[0][23:16], 8'h44);
    chk("s3_q0",   q[0][7:0], 8'h00);
    drop(0, 1, "s3_b");
    wait_ack(0, 0, 2, "s3_a");
    chk("s3_q0b",  q[0][7:0], 8'h33);
    chk("s3_full", full[0], 4'b0111);
    drop(0, 0, "s3_a");

    rst[0] = 1'b1;
    @(negedge Clk);
    rst[0] = 1'b0;
    chk("rst2_q",    q[0], 32'h0);
    chk("rst2_full", full[0], 4'b0000);

    // last = B after reset: A first
    rqst(0, 0, 2'd0, 8'h11);
    rqst(0, 1, 2'd2, 8'h22);
    wait_ack(0, 0, 2, "s2_a");
    chk("s2_q0", q[0][7:0], 8'h11);
    drop(0, 0, "s2_a");
    wait_ack(0, 1, 2, "s2_b");
    chk("s2_q2",   q[0][23:16], 8'h22);
    chk("s2_full", full[0], 4'b0101);
    drop(0, 1, "s2_b");

    // Clear on latch 2 coincides with WR to latch 2; clear on latch 0 still applies
    rqst(0, 0, 2'd2, 8'h55);
    @(negedge Clk);
    clr[0] = 4'b0101;
    @(negedge Clk);
    clr[0] = 4'b0000;
    chk("s5_full", full[0], 4'b0100);
    chk("s5_ack",  a_ack[0], 1);
    chk("s5_q2",   q[0][23:16], 8'h55);
    drop(0, 0, "s5");

    // Reset while B is in ACK
    rqst(0, 1, 2'd1, 8'h66);
    wait_ack(0, 1, 2, "s6");
    chk("s6_q1", q[0][15:8], 8'h66);
    rst[0] = 1'b1;
    b_req[0] = 1'b0;
    @(negedge Clk);
    rst[0] = 1'b0;
    chk("s6_back", b_ack[0], 0);
    chk("s6_q",    q[0], 32'h0);
    chk("s6_full", full[0], 4'b0000);
    chk("s6_busy", busy[0], 0);

    // STRICT: fill latch 3, then A stalls on it while B proceeds
    rqst(1, 0, 2'd3, 8'h77);
    wait_ack(1, 0, 2, "s4_fill");
    drop(1, 0, "s4_fill");
    chk("s4_full0", full[1], 4'b1000);
    rqst(1, 0, 2'd3, 8'h88);
    rqst(1, 1, 2'd0, 8'h99);
    wait_ack(1, 1, 2, "s4_b");
    chk("s4_q0", q[1][7:0], 8'h99);
    drop(1, 1, "s4_b");
    repeat (3) @(negedge Clk);
    chk("s4_stall_ack",  a_ack[1], 0);
    chk("s4_stall_busy", busy[1], 0);
    chk("s4_stall_q3",   q[1][31:24], 8'h77);
    clr[1] = 4'b1000;
    @(negedge Clk);
    clr[1] = 4'b0000;
    wait_ack(1, 0, 2, "s4_a");
    chk("s4_q3",   q[1][31:24], 8'h88);
    chk("s4_full", full[1], 4'b1001);
    drop(1, 0, "s4_a");

    // NREG=3: address 3 is out of range
    rqst(2, 0, 2'd1, 8'hAB);
    wait_ack(2, 0, 2, "s7_in");
    drop(2, 0, "s7_in");
    rqst(2, 0, 2'd3, 8'hCD);
    wait_ack(2, 0, 2, "s7_oor");
    chk("s7_q",    q[2], 32'h0000AB00);
    chk("s7_full", full[2], 4'b0010);
    drop(2, 0, "s7_oor");

    chk("acks_exclusive", both_hi, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1, "timeout");
  end

endmodule
